// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one bit per clock.
// Handshake or change-triggered start, overflow flag and leading-zero mask.
module bin2bcd_seq #(
    parameter int BIN_W     = 10,
    parameter int DIGITS    = 4,
    parameter int ON_CHANGE = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [BIN_W-1:0]      bin_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     blank,
    output logic                  overflow,
    output logic                  out_valid
);

    localparam int SW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_W + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(BIN_W - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [BIN_W-1:0]  bin_q, bin_d;
    logic [BIN_W-1:0]  last_q, last_d;
    logic [SW-1:0]     scr_q, scr_d;
    logic              carry_q, carry_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SW-1:0]     bcd_q, bcd_d;
    logic [DIGITS-1:0] blank_q, blank_d;
    logic              ovf_q, ovf_d;
    logic              ovalid_q, ovalid_d;

    logic [SW-1:0]     adj;
    logic [SW-1:0]     scr_nxt;
    logic [BIN_W-1:0]  bin_nxt;
    logic              cout;
    logic              zero_run;
    logic [DIGITS-1:0] blk;
    logic              accept;
    logic              last_cnt;

    always_comb begin
        adj = scr_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (scr_q[4*d +: 4] >= 4'd5) begin
                adj[4*d +: 4] = scr_q[4*d +: 4] + 4'd3;
            end
        end
        cout    = adj[SW-1];
        scr_nxt = {adj[SW-2:0], bin_q[BIN_W-1]};
        bin_nxt = bin_q << 1;
    end

    // Digit i blanks only if it and every digit above it are zero.
    always_comb begin
        blk      = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run = zero_run & (scr_nxt[4*i +: 4] == 4'd0);
            blk[i]   = zero_run;
        end
    end

    assign accept = (ON_CHANGE != 0) ? (bin_in != last_q) : in_valid;
    assign last_cnt = (cnt_q == LAST_CNT);

    always_comb begin
        state_d  = state_q;
        bin_d    = bin_q;
        last_d   = last_q;
        scr_d    = scr_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        bcd_d    = bcd_q;
        blank_d  = blank_q;
        ovf_d    = ovf_q;
        ovalid_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    bin_d   = bin_in;
                    last_d  = bin_in;
                    scr_d   = '0;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                bin_d   = bin_nxt;
                scr_d   = scr_nxt;
                carry_d = carry_q | cout;
                cnt_d   = cnt_q + CW'(1);
                if (last_cnt) begin
                    bcd_d    = scr_nxt;
                    blank_d  = blk;
                    ovf_d    = carry_q | cout;
                    ovalid_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            bin_q    <= '0;
            last_q   <= '0;
            scr_q    <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            bcd_q    <= '0;
            blank_q  <= '0;
            ovf_q    <= 1'b0;
            ovalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            bin_q    <= bin_d;
            last_q   <= last_d;
            scr_q    <= scr_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            bcd_q    <= bcd_d;
            blank_q  <= blank_d;
            ovf_q    <= ovf_d;
            ovalid_q <= ovalid_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign bcd_out   = bcd_q;
    assign blank     = blank_q;
    assign overflow  = ovf_q;
    assign out_valid = ovalid_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: five configurations checked against an
// arithmetic decimal model, directed corners plus random values.
module tb_bin2bcd_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] bin;
    logic        vld;
    logic [9:0]  c_bin;
    logic        c_vld;

    logic a_rdy, a_ovf, a_ov;
    logic [15:0] a_bcd;
    logic [3:0]  a_blk;
    logic b_rdy, b_ovf, b_ov;
    logic [7:0]  b_bcd;
    logic [1:0]  b_blk;
    logic c_rdy, c_ovf, c_ov;
    logic [15:0] c_bcd;
    logic [3:0]  c_blk;
    logic d_rdy, d_ovf, d_ov;
    logic [3:0]  d_bcd;
    logic [0:0]  d_blk;
    logic e_rdy, e_ovf, e_ov;
    logic [19:0] e_bcd;
    logic [4:0]  e_blk;

    bin2bcd_seq #(.BIN_W(10), .DIGITS(4), .ON_CHANGE(0)) u_a (
        .clk(clk), .rst_n(rst_n), .bin_in(bin[9:0]), .in_valid(vld),
        .in_ready(a_rdy), .bcd_out(a_bcd), .blank(a_blk),
        .overflow(a_ovf), .out_valid(a_ov));
    bin2bcd_seq #(.BIN_W(10), .DIGITS(2), .ON_CHANGE(0)) u_b (
        .clk(clk), .rst_n(rst_n), .bin_in(bin[9:0]), .in_valid(vld),
        .in_ready(b_rdy), .bcd_out(b_bcd), .blank(b_blk),
        .overflow(b_ovf), .out_valid(b_ov));
    bin2bcd_seq #(.BIN_W(10), .DIGITS(4), .ON_CHANGE(1)) u_c (
        .clk(clk), .rst_n(rst_n), .bin_in(c_bin), .in_valid(c_vld),
        .in_ready(c_rdy), .bcd_out(c_bcd), .blank(c_blk),
        .overflow(c_ovf), .out_valid(c_ov));
    bin2bcd_seq #(.BIN_W(1), .DIGITS(1), .ON_CHANGE(0)) u_d (
        .clk(clk), .rst_n(rst_n), .bin_in(bin[0:0]), .in_valid(vld),
        .in_ready(d_rdy), .bcd_out(d_bcd), .blank(d_blk),
        .overflow(d_ovf), .out_valid(d_ov));
    bin2bcd_seq #(.BIN_W(16), .DIGITS(5), .ON_CHANGE(0)) u_e (
        .clk(clk), .rst_n(rst_n), .bin_in(bin), .in_valid(vld),
        .in_ready(e_rdy), .bcd_out(e_bcd), .blank(e_blk),
        .overflow(e_ovf), .out_valid(e_ov));

    logic        o_rdy[5];
    logic        o_ov[5];
    logic        o_ovf[5];
    logic [31:0] o_bcd[5];
    logic [7:0]  o_blk[5];

    assign o_rdy[0] = a_rdy;  assign o_ov[0] = a_ov;  assign o_ovf[0] = a_ovf;
    assign o_rdy[1] = b_rdy;  assign o_ov[1] = b_ov;  assign o_ovf[1] = b_ovf;
    assign o_rdy[2] = c_rdy;  assign o_ov[2] = c_ov;  assign o_ovf[2] = c_ovf;
    assign o_rdy[3] = d_rdy;  assign o_ov[3] = d_ov;  assign o_ovf[3] = d_ovf;
    assign o_rdy[4] = e_rdy;  assign o_ov[4] = e_ov;  assign o_ovf[4] = e_ovf;
    assign o_bcd[0] = 32'(a_bcd);  assign o_blk[0] = 8'(a_blk);
    assign o_bcd[1] = 32'(b_bcd);  assign o_blk[1] = 8'(b_blk);
    assign o_bcd[2] = 32'(c_bcd);  assign o_blk[2] = 8'(c_blk);
    assign o_bcd[3] = 32'(d_bcd);  assign o_blk[3] = 8'(d_blk);
    assign o_bcd[4] = 32'(e_bcd);  assign o_blk[4] = 8'(e_blk);

    int BW[5] = '{10, 10, 10, 1, 16};
    int DG[5] = '{4, 2, 4, 1, 5};
    int HS[4] = '{0, 1, 3, 4};

    int n_chk = 0;
    int n_err = 0;

    int          pc[5];
    int          pl[5][2];
    logic [31:0] pb[5][2];
    logic [7:0]  pk[5][2];
    logic        po[5][2];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Decimal model: truncate modulo 10^dig, digits by repeated division.
    task automatic ref_conv(input int v, input int dig,
                            output logic [31:0] bcd,
                            output logic [7:0] blk,
                            output logic ovf);
        int p, r, t, pw;
        p = 1;
        for (int i = 0; i < dig; i++) p = p * 10;
        ovf = (v >= p);
        r = v % p;
        bcd = '0;
        t = r;
        for (int i = 0; i < dig; i++) begin
            bcd = bcd | (32'(t % 10) << (4 * i));
            t = t / 10;
        end
        blk = '0;
        pw = 1;
        for (int i = 1; i < dig; i++) begin
            pw = pw * 10;
            blk[i] = (r < pw);
        end
    endtask

    task automatic watch(input int ncyc);
        for (int i = 0; i < 5; i++) pc[i] = 0;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            for (int i = 0; i < 5; i++) begin
                if (o_ov[i]) begin
                    if (pc[i] < 2) begin
                        pl[i][pc[i]] = k;
                        pb[i][pc[i]] = o_bcd[i];
                        pk[i][pc[i]] = o_blk[i];
                        po[i][pc[i]] = o_ovf[i];
                    end
                    pc[i]++;
                end
            end
        end
    endtask

    task automatic check_one(input int i, input int v, input string nm);
        logic [31:0] eb;
        logic [7:0]  ek;
        logic        eo;
        ref_conv(v, DG[i], eb, ek, eo);
        chk($sformatf("%s.%0d.pulses", nm, i), 32'(pc[i]), 32'd1);
        if (pc[i] >= 1) begin
            chk($sformatf("%s.%0d.lat", nm, i), 32'(pl[i][0]), 32'(BW[i]));
            chk($sformatf("%s.%0d.bcd", nm, i), pb[i][0], eb);
            chk($sformatf("%s.%0d.blank", nm, i), 32'(pk[i][0]), 32'(ek));
            chk($sformatf("%s.%0d.ovf", nm, i), 32'(po[i][0]), 32'(eo));
        end
    endtask

    task automatic run_vec(input int v);
        @(negedge clk);
        bin = 16'(v);
        vld = 1'b1;
        foreach (HS[j]) chk($sformatf("rdy_idle.%0d", HS[j]),
                            32'(o_rdy[HS[j]]), 32'd1);
        @(negedge clk);
        vld = 1'b0;
        foreach (HS[j]) chk($sformatf("rdy_busy.%0d", HS[j]),
                            32'(o_rdy[HS[j]]), 32'd0);
        watch(18);
        foreach (HS[j]) begin
            int i;
            i = HS[j];
            check_one(i, v & ((1 << BW[i]) - 1), $sformatf("v%0d", v));
        end
    endtask

    task automatic chk_zero(input string nm);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("%s.%0d.bcd", nm, i), o_bcd[i], 32'd0);
            chk($sformatf("%s.%0d.blank", nm, i), 32'(o_blk[i]), 32'd0);
            chk($sformatf("%s.%0d.ovf", nm, i), 32'(o_ovf[i]), 32'd0);
            chk($sformatf("%s.%0d.ov", nm, i), 32'(o_ov[i]), 32'd0);
            chk($sformatf("%s.%0d.rdy", nm, i), 32'(o_rdy[i]), 32'd1);
        end
    endtask

    int dir_v[10] = '{1000, 7, 0, 999, 99, 100, 1, 65535, 255, 256};

    initial begin
        int p1, p2, k, cv;
        logic [31:0] b1, b2;
        bin = '0; vld = 1'b0; c_bin = '0; c_vld = 1'b0;

        // reset held with random inputs
        repeat (3) begin
            @(negedge clk);
            bin = 16'($urandom);
            vld = 1'($urandom);
            c_bin = 10'($urandom);
            c_vld = 1'($urandom);
            #1 chk_zero("rst_hold");
        end
        @(negedge clk);
        vld = 1'b0; c_bin = '0; bin = '0;
        @(negedge clk);
        rst_n = 1'b1;

        foreach (dir_v[j]) run_vec(dir_v[j]);

        // reset mid-SHIFT, five cycles after accept
        @(negedge clk);
        bin = 16'd1000; vld = 1'b1;
        @(negedge clk);
        vld = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1 chk_zero("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        watch(20);
        for (int i = 0; i < 5; i++)
            chk($sformatf("no_stale.%0d", i), 32'(pc[i]), 32'd0);

        // back-to-back with in_valid held high
        @(negedge clk);
        bin = 16'd255; vld = 1'b1;
        p1 = -1; p2 = -1; b1 = '0; b2 = '0;
        k = 0;
        while (p2 < 0 && k < 40) begin
            @(negedge clk);
            chk($sformatf("b2b.rdy.k%0d", k), 32'(a_rdy), 32'(a_ov));
            if (a_ov) begin
                if (p1 < 0) begin
                    p1 = k; b1 = o_bcd[0]; bin = 16'd256;
                end else begin
                    p2 = k; b2 = o_bcd[0]; vld = 1'b0;
                end
            end
            k++;
        end
        vld = 1'b0;
        chk("b2b.first_at", 32'(p1), 32'd10);
        chk("b2b.first_bcd", b1, 32'h0255);
        chk("b2b.spacing", 32'(p2 - p1), 32'd11);
        chk("b2b.second_bcd", b2, 32'h0256);
        repeat (40) @(negedge clk);

        for (int v = 0; v < 1024; v++) run_vec(v);
        repeat (100) run_vec(int'($urandom_range(0, 65535)));

        // change-triggered instance
        watch(20);
        chk("oc.idle_zero", 32'(pc[2]), 32'd0);
        @(negedge clk);
        c_bin = 10'd42; c_vld = 1'($urandom);
        @(negedge clk);
        chk("oc.busy", 32'(c_rdy), 32'd0);
        watch(15);
        check_one(2, 42, "oc42");
        watch(50);
        chk("oc.hold", 32'(pc[2]), 32'd0);
        @(negedge clk);
        c_bin = 10'd44;
        repeat (4) @(negedge clk);
        c_bin = 10'd43;
        watch(30);
        chk("oc.chg.pulses", 32'(pc[2]), 32'd2);
        chk("oc.chg.first", pb[2][0], 32'h0044);
        chk("oc.chg.second", pb[2][1], 32'h0043);
        chk("oc.chg.spacing", 32'(pl[2][1] - pl[2][0]), 32'd11);
        cv = 43;
        repeat (20) begin
            int nv;
            nv = int'($urandom_range(0, 1023));
            if (nv == cv) nv = nv ^ 1;
            cv = nv;
            @(negedge clk);
            c_bin = 10'(nv); c_vld = 1'($urandom);
            @(negedge clk);
            watch(15);
            check_one(2, nv, "ocr");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
